lcd_panel_model: RTL



---
 rtl/lcd_panel_model.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_panel_model.sv
// Panel-side responder for the 8-bit HD44780-style text-LCD bus: decodes
// instructions and data, holds DDRAM, AC and mode flags, models busy timing.
module lcd_panel_model #(
  parameter int BUSY_SHORT = 2000,
  parameter int BUSY_LONG  = 82000,
  parameter int MIN_E_PW   = 12,
  parameter bit POR_CLEAR  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_din,
  output logic [7:0] lcd_dout,
  output logic       lcd_doe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] ac,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       incr,
  output logic       shift_en,
  output logic       dl8,
  output logic       two_line,
  output logic       font,
  output logic [15:0] wr_count,
  output logic       pw_err,
  output logic       busy_err,
  output logic       rw_err
);

  localparam int BUSY_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
  localparam int BW = $clog2(BUSY_MAX + 1);
  localparam int EW = $clog2(MIN_E_PW + 1);
  localparam logic [BW-1:0] SHORT_LD = BW'(BUSY_SHORT);
  localparam logic [BW-1:0] LONG_LD  = BW'(BUSY_LONG);
  localparam logic [EW-1:0] E_MIN    = EW'(MIN_E_PW);

  typedef enum logic {SEQ_IDLE, SEQ_FILL} seq_state_e;

  logic [7:0]    mem [128];

  logic          rs_q, rw_q, e_q;
  logic [7:0]    din_q;
  logic [EW-1:0] e_cnt_q, e_cnt_d;
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic [6:0]    ac_q, ac_d;
  logic          disp_on_q, disp_on_d, cursor_on_q, cursor_on_d, blink_on_q, blink_on_d;
  logic          incr_q, incr_d, shift_en_q, shift_en_d;
  logic          dl8_q, dl8_d, two_line_q, two_line_d, font_q, font_d;
  logic [15:0]   wr_count_q, wr_count_d;
  logic          pw_err_q, pw_err_d, busy_err_q, busy_err_d, rw_err_q, rw_err_d;
  seq_state_e    seq_state_q, seq_state_d;
  logic [6:0]    seq_addr_q, seq_addr_d;
  logic          por_q;
  logic [7:0]    dout_q, rd_data_q;

  logic          busy_w, e_fall, start_clear, bus_we;
  logic          mem_we;
  logic [6:0]    mem_waddr;
  logic [7:0]    mem_wdata;

  assign busy_w = (busy_cnt_q != '0);
  assign e_fall = e_q & ~lcd_e;

  // Two-line mode jumps between the visible windows 0x00-0x27 and 0x40-0x67.
  function automatic logic [6:0] adv_ac(input logic [6:0] a, input logic up,
                                        input logic two);
    logic [6:0] n;
    n = up ? a + 7'd1 : a - 7'd1;
    if (two) begin
      if (up && a == 7'h27)       n = 7'h40;
      else if (up && a == 7'h67)  n = 7'h00;
      else if (!up && a == 7'h40) n = 7'h27;
      else if (!up && a == 7'h00) n = 7'h67;
    end
    return n;
  endfunction

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    e_cnt_d     = e_cnt_q;
    busy_cnt_d  = busy_w ? busy_cnt_q - BW'(1) : busy_cnt_q;
    ac_d        = ac_q;
    disp_on_d   = disp_on_q;
    cursor_on_d = cursor_on_q;
    blink_on_d  = blink_on_q;
    incr_d      = incr_q;
    shift_en_d  = shift_en_q;
    dl8_d       = dl8_q;
    two_line_d  = two_line_q;
    font_d      = font_q;
    wr_count_d  = wr_count_q;
    pw_err_d    = pw_err_q;
    busy_err_d  = busy_err_q;
    rw_err_d    = rw_err_q;
    seq_state_d = seq_state_q;
    seq_addr_d  = seq_addr_q;
    start_clear = por_q;
    bus_we      = 1'b0;

    if (!lcd_e)                e_cnt_d = '0;
    else if (e_cnt_q != E_MIN) e_cnt_d = e_cnt_q + EW'(1);

    case (seq_state_q)
      SEQ_FILL: begin
        seq_addr_d = seq_addr_q + 7'd1;
        if (seq_addr_q == 7'h7F) seq_state_d = SEQ_IDLE;
      end
      default: ;
    endcase

    if (e_fall) begin
      if (e_cnt_q < E_MIN) begin
        pw_err_d = 1'b1;
      end else begin
        if (rw_q && !dl8_q) rw_err_d = 1'b1;
        if (rw_q && !rs_q) begin
          // Busy-flag/address read has no side effects and is always legal.
        end else if (busy_w) begin
          busy_err_d = 1'b1;
        end else begin
          busy_cnt_d = SHORT_LD;
          if (rw_q) begin
            ac_d = adv_ac(ac_q, incr_q, two_line_q);
          end else if (rs_q) begin
            bus_we = 1'b1;
            ac_d   = adv_ac(ac_q, incr_q, two_line_q);
            if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
          end else begin
            priority casez (din_q)
              8'b1???????: ac_d = din_q[6:0];
              8'b01??????: ;
              8'b001?????: {dl8_d, two_line_d, font_d} = din_q[4:2];
              8'b0001????: if (!din_q[3]) ac_d = adv_ac(ac_q, din_q[2], two_line_q);
              8'b00001???: {disp_on_d, cursor_on_d, blink_on_d} = din_q[2:0];
              8'b000001??: {incr_d, shift_en_d} = din_q[1:0];
              8'b0000001?: begin
                ac_d       = 7'h00;
                busy_cnt_d = LONG_LD;
              end
              8'b00000001: start_clear = 1'b1;
              default: ;
            endcase
          end
        end
      end
    end

    if (start_clear) begin
      ac_d        = 7'h00;
      incr_d      = 1'b1;
      busy_cnt_d  = LONG_LD;
      seq_state_d = SEQ_FILL;
      seq_addr_d  = 7'h00;
    end

    // The fill owns the write port; a bus write cannot coincide since it is busy.
    mem_we    = (seq_state_q == SEQ_FILL) | bus_we;
    mem_waddr = (seq_state_q == SEQ_FILL) ? seq_addr_q : ac_q;
    mem_wdata = (seq_state_q == SEQ_FILL) ? 8'h20 : din_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      e_q         <= 1'b0;
      din_q       <= 8'h00;
      e_cnt_q     <= '0;
      busy_cnt_q  <= '0;
      ac_q        <= 7'h00;
      disp_on_q   <= 1'b0;
      cursor_on_q <= 1'b0;
      blink_on_q  <= 1'b0;
      incr_q      <= 1'b1;
      shift_en_q  <= 1'b0;
      dl8_q       <= 1'b0;
      two_line_q  <= 1'b0;
      font_q      <= 1'b0;
      wr_count_q  <= 16'h0000;
      pw_err_q    <= 1'b0;
      busy_err_q  <= 1'b0;
      rw_err_q    <= 1'b0;
      seq_state_q <= SEQ_IDLE;
      seq_addr_q  <= 7'h00;
      por_q       <= POR_CLEAR;
      dout_q      <= 8'h00;
      rd_data_q   <= 8'h00;
    end else begin
      rs_q        <= lcd_rs;
      rw_q        <= lcd_rw;
      e_q         <= lcd_e;
      din_q       <= lcd_din;
      e_cnt_q     <= e_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      ac_q        <= ac_d;
      disp_on_q   <= disp_on_d;
      cursor_on_q <= cursor_on_d;
      blink_on_q  <= blink_on_d;
      incr_q      <= incr_d;
      shift_en_q  <= shift_en_d;
      dl8_q       <= dl8_d;
      two_line_q  <= two_line_d;
      font_q      <= font_d;
      wr_count_q  <= wr_count_d;
      pw_err_q    <= pw_err_d;
      busy_err_q  <= busy_err_d;
      rw_err_q    <= rw_err_d;
      seq_state_q <= seq_state_d;
      seq_addr_q  <= seq_addr_d;
      por_q       <= 1'b0;
      dout_q      <= lcd_rs ? mem[ac_q] : {busy_w, ac_q};
      rd_data_q   <= mem[rd_addr];
    end
  end

  // NOTE: DDRAM is deliberately not reset, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign lcd_dout  = dout_q;
  assign lcd_doe   = e_q & rw_q;
  assign rd_data   = rd_data_q;
  assign ac        = ac_q;
  assign busy      = busy_w;
  assign disp_on   = disp_on_q;
  assign cursor_on = cursor_on_q;
  assign blink_on  = blink_on_q;
  assign incr      = incr_q;
  assign shift_en  = shift_en_q;
  assign dl8       = dl8_q;
  assign two_line  = two_line_q;
  assign font      = font_q;
  assign wr_count  = wr_count_q;
  assign pw_err    = pw_err_q;
  assign busy_err  = busy_err_q;
  assign rw_err    = rw_err_q;

endmodule
